bnn_pingpong_obuf: RTL

- Parametrised multi-bank output feature-map buffer between a BNN layer datapath (writer) and off-chip or next-layer readers.
- Generalises the fixed two-bank next-layer SRAM pair: NBANK banks, configurable word width and depth, and runtime frame length.
- Bank-level full/empty handshake is built into the block; no external control FSM is needed.
- The writer streams words sequentially. The reader random-accesses a full bank and releases it.

---
 rtl/bnn_obuf_pkg.sv | 23 ++
 rtl/bnn_obuf_bank.sv | 30 +++
 rtl/bnn_pingpong_obuf.sv | 129 ++++++++++++
 3 files changed

// File: rtl/bnn_obuf_pkg.sv
// Shared defaults and helpers for the BNN ping-pong output buffer.
package bnn_obuf_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 2048;
  localparam int DEF_NBANK  = 2;

  // Ceiling log2; returns 0 for values <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) r = r + 1;
    end
    return r;
  endfunction

  // Frame length actually used: 0 or anything larger than a bank means a full bank.
  function automatic int unsigned eff_len(input int unsigned frame_len, input int unsigned depth);
    return (frame_len == 0 || frame_len > depth) ? depth : frame_len;
  endfunction

endpackage

// File: rtl/bnn_obuf_bank.sv
// One bank of the output buffer: simple dual-port RAM with registered read.
module bnn_obuf_bank
  import bnn_obuf_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = clog2(DEPTH)
)(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port; contents are deliberately left unreset so this maps to block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port; holds its last value when not enabled.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/bnn_pingpong_obuf.sv
// Multi-bank ring buffer between a BNN layer writer and a random-access reader,
// with bank-level full/empty handshaking built in.
module bnn_pingpong_obuf
  import bnn_obuf_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = clog2(DEPTH),
  parameter int NBANK  = DEF_NBANK,
  parameter int BANK_W = clog2(NBANK)
)(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W:0]   frame_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              rd_release,
  output logic [NBANK-1:0]  bank_full,
  output logic [BANK_W-1:0] wr_bank,
  output logic [BANK_W-1:0] rd_bank,
  output logic              frame_done,
  output logic [BANK_W:0]   occupancy
);

  localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NBANK - 1);

  logic [ADDR_W-1:0] wptr_reg, wptr_next;
  logic [BANK_W-1:0] wr_bank_reg, wr_bank_next;
  logic [BANK_W-1:0] rd_bank_reg, rd_bank_next;
  logic [NBANK-1:0]  bank_full_reg, bank_full_next;
  logic [BANK_W:0]   occupancy_reg, occupancy_next;
  logic              frame_done_reg;
  logic              rd_valid_reg;
  logic              rd_oob_reg;
  logic [BANK_W-1:0] rd_sel_reg;

  logic [ADDR_W:0]   eff_len_w;
  logic              wr_acc, wr_last, rd_acc, rd_oob, rel_acc;
  logic [DATA_W-1:0] bank_q [NBANK];

  assign eff_len_w = (ADDR_W + 1)'(eff_len(32'(frame_len), 32'(DEPTH)));
  assign wr_ready  = rst & ~bank_full_reg[wr_bank_reg];
  assign wr_acc    = wr_valid & wr_ready;
  assign wr_last   = ({1'b0, wptr_reg} == (eff_len_w - (ADDR_W + 1)'(1)));
  assign rd_acc    = rd_en & bank_full_reg[rd_bank_reg];
  assign rd_oob    = ({1'b0, rd_addr} >= eff_len_w);
  assign rel_acc   = rd_release & bank_full_reg[rd_bank_reg];

  // Next-state for pointers and full flags; a completing write and a release can coincide.
  always_comb begin
    wptr_next      = wptr_reg;
    wr_bank_next   = wr_bank_reg;
    rd_bank_next   = rd_bank_reg;
    bank_full_next = bank_full_reg;
    occupancy_next = '0;
    if (wr_acc) begin
      if (wr_last) begin
        wptr_next                   = '0;
        bank_full_next[wr_bank_reg] = 1'b1;
        wr_bank_next = (wr_bank_reg == LAST_BANK) ? '0 : wr_bank_reg + BANK_W'(1);
      end else begin
        wptr_next = wptr_reg + ADDR_W'(1);
      end
    end
    if (rel_acc) begin
      bank_full_next[rd_bank_reg] = 1'b0;
      rd_bank_next = (rd_bank_reg == LAST_BANK) ? '0 : rd_bank_reg + BANK_W'(1);
    end
    for (int i = 0; i < NBANK; i++) begin
      occupancy_next = occupancy_next + (BANK_W + 1)'(bank_full_next[i]);
    end
  end

  // Control state register; reset discards partial and completed frames.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_reg       <= '0;
      wr_bank_reg    <= '0;
      rd_bank_reg    <= '0;
      bank_full_reg  <= '0;
      occupancy_reg  <= '0;
      frame_done_reg <= 1'b0;
      rd_valid_reg   <= 1'b0;
      rd_oob_reg     <= 1'b0;
      rd_sel_reg     <= '0;
    end else begin
      wptr_reg       <= wptr_next;
      wr_bank_reg    <= wr_bank_next;
      rd_bank_reg    <= rd_bank_next;
      bank_full_reg  <= bank_full_next;
      occupancy_reg  <= occupancy_next;
      frame_done_reg <= wr_acc & wr_last;
      rd_valid_reg   <= rd_acc;
      rd_oob_reg     <= rd_acc & rd_oob;
      rd_sel_reg     <= rd_bank_reg;
    end
  end

  // Bank array; read select is the pre-release bank captured with the read.
  for (genvar gi = 0; gi < NBANK; gi++) begin : g_bank
    bnn_obuf_bank #(
      .DATA_W(DATA_W),
      .DEPTH (DEPTH),
      .ADDR_W(ADDR_W)
    ) u_bank (
      .clk  (clk),
      .we   (wr_acc && (wr_bank_reg == BANK_W'(gi))),
      .waddr(wptr_reg),
      .wdata(wr_data),
      .re   (rd_acc && !rd_oob && (rd_bank_reg == BANK_W'(gi))),
      .raddr(rd_addr),
      .rdata(bank_q[gi])
    );
  end

  assign rd_data    = (rd_valid_reg && !rd_oob_reg) ? bank_q[rd_sel_reg] : '0;
  assign rd_valid   = rd_valid_reg;
  assign bank_full  = bank_full_reg;
  assign wr_bank    = wr_bank_reg;
  assign rd_bank    = rd_bank_reg;
  assign frame_done = frame_done_reg;
  assign occupancy  = occupancy_reg;

endmodule
